// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory access controller: owns MAR/MDR, sequences SRAM strobes with a
// programmable wait-state count and latches read data into RDATA.
// Optional feature: define MEM_CTRL_ERR_EN to enable sticky dropped-request Err.
module lc3_mem_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        LD_MAR,
    input  logic        LD_MDR,
    input  logic        MIO_EN,
    input  logic [15:0] Bus_in,
    input  logic        Rd_req,
    input  logic        Wr_req,
    input  logic [15:0] Mem_rdata,
    output logic [15:0] MAR,
    output logic [15:0] MDR,
    output logic [15:0] Mem_addr,
    output logic [15:0] Mem_wdata,
    output logic        Mem_CE_n,
    output logic        Mem_OE_n,
    output logic        Mem_WE_n,
    output logic        Busy,
    output logic        Done,
    output logic        Err
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        WRITE   = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   mar_q;
    logic [DATA_W-1:0]   mdr_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                ce_n_q;
    logic                oe_n_q;
    logic                we_n_q;
    logic                busy_q;
    logic                done_q;

    // Access sequencer; strobes are registered alongside the state so they
    // always equal the decode of the current state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            mar_q   <= '0;
            mdr_q   <= '0;
            rdata_q <= '0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (LD_MAR) mar_q <= Bus_in;
                    if (LD_MDR) mdr_q <= MIO_EN ? rdata_q : Bus_in;
                    if (Rd_req) begin
                        state  <= READ;
                        cnt    <= CNT_W'(WAIT_CYCLES);
                        ce_n_q <= 1'b0;
                        oe_n_q <= 1'b0;
                        busy_q <= 1'b1;
                    end else if (Wr_req) begin
                        state  <= WRITE;
                        cnt    <= CNT_W'(WAIT_CYCLES);
                        ce_n_q <= 1'b0;
                        we_n_q <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                READ: begin
                    // MIO_EN selects the RDATA value held before this edge
                    if (LD_MDR) mdr_q <= MIO_EN ? rdata_q : Bus_in;
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        rdata_q <= Mem_rdata;
                        state   <= IDLE;
                        ce_n_q  <= 1'b1;
                        oe_n_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                WRITE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        // WE_n releases one cycle ahead of CE_n for data hold
                        state  <= RECOVER;
                        we_n_q <= 1'b1;
                    end
                end
                RECOVER: begin
                    state  <= IDLE;
                    ce_n_q <= 1'b1;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    ce_n_q <= 1'b1;
                    oe_n_q <= 1'b1;
                    we_n_q <= 1'b1;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_CTRL_ERR_EN
    logic err_q;

    // Sticky flag for requests dropped while busy or by a read/write collision
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            err_q <= 1'b0;
        end else if (((state != IDLE) && (Rd_req || Wr_req)) ||
                     ((state == IDLE) && Rd_req && Wr_req)) begin
            err_q <= 1'b1;
        end
    end

    assign Err = err_q;
`else
    assign Err = 1'b0;
`endif

    assign MAR       = mar_q;
    assign MDR       = mdr_q;
    assign Mem_addr  = mar_q;
    assign Mem_wdata = mdr_q;
    assign Mem_CE_n  = ce_n_q;
    assign Mem_OE_n  = oe_n_q;
    assign Mem_WE_n  = we_n_q;
    assign Busy      = busy_q;
    assign Done      = done_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Self-checking bench for lc3_mem_ctrl: access-level reference model plus
// directed scenarios and randomized traffic.
module tb_lc3_mem_ctrl;

    localparam int unsigned W = 2;
`ifdef MEM_CTRL_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        Clk;
    logic        Reset_n;
    logic        LD_MAR;
    logic        LD_MDR;
    logic        MIO_EN;
    logic [15:0] Bus_in;
    logic        Rd_req;
    logic        Wr_req;
    logic [15:0] Mem_rdata;
    logic [15:0] MAR;
    logic [15:0] MDR;
    logic [15:0] Mem_addr;
    logic [15:0] Mem_wdata;
    logic        Mem_CE_n;
    logic        Mem_OE_n;
    logic        Mem_WE_n;
    logic        Busy;
    logic        Done;
    logic        Err;

    int checks;
    int failures;

    lc3_mem_ctrl #(.WAIT_CYCLES(W)) dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .LD_MAR   (LD_MAR),
        .LD_MDR   (LD_MDR),
        .MIO_EN   (MIO_EN),
        .Bus_in   (Bus_in),
        .Rd_req   (Rd_req),
        .Wr_req   (Wr_req),
        .Mem_rdata(Mem_rdata),
        .MAR      (MAR),
        .MDR      (MDR),
        .Mem_addr (Mem_addr),
        .Mem_wdata(Mem_wdata),
        .Mem_CE_n (Mem_CE_n),
        .Mem_OE_n (Mem_OE_n),
        .Mem_WE_n (Mem_WE_n),
        .Busy     (Busy),
        .Done     (Done),
        .Err      (Err)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Reference model: tracks the access in flight by kind and cycle age
    int          m_kind;   // 0 none, 1 read, 2 write
    int          m_age;    // cycles since the accepting edge
    logic [15:0] m_mar;
    logic [15:0] m_mdr;
    logic [15:0] m_rdata;
    logic        m_done;
    logic        m_err;

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_kind = 0; m_age = 0; m_mar = 16'h0; m_mdr = 16'h0;
            m_rdata = 16'h0; m_done = 1'b0; m_err = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_kind == 0) begin
                if (LD_MAR) m_mar = Bus_in;
                if (LD_MDR) m_mdr = MIO_EN ? m_rdata : Bus_in;
                if (Rd_req && Wr_req && ERR_EN) m_err = 1'b1;
                if (Rd_req) begin
                    m_kind = 1; m_age = 1;
                end else if (Wr_req) begin
                    m_kind = 2; m_age = 1;
                end
            end else begin
                if ((Rd_req || Wr_req) && ERR_EN) m_err = 1'b1;
                if (m_kind == 1 && LD_MDR) m_mdr = MIO_EN ? m_rdata : Bus_in;
                if (m_kind == 1 && m_age == int'(W) + 1) begin
                    m_rdata = Mem_rdata; m_kind = 0; m_done = 1'b1;
                end else if (m_kind == 2 && m_age == int'(W) + 2) begin
                    m_kind = 0; m_done = 1'b1;
                end else begin
                    m_age = m_age + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and compare every output with the model
    task automatic cyc();
        logic [2:0] exp_strb;
        @(negedge Clk);
        exp_strb[2] = (m_kind != 0) ? 1'b0 : 1'b1;
        exp_strb[1] = (m_kind == 1) ? 1'b0 : 1'b1;
        exp_strb[0] = (m_kind == 2 && m_age <= int'(W) + 1) ? 1'b0 : 1'b1;
        chk("model_mar", 32'(MAR), 32'(m_mar));
        chk("model_mdr", 32'(MDR), 32'(m_mdr));
        chk("model_addr", 32'(Mem_addr), 32'(m_mar));
        chk("model_wdata", 32'(Mem_wdata), 32'(m_mdr));
        chk("model_strobes", 32'({Mem_CE_n, Mem_OE_n, Mem_WE_n}), 32'(exp_strb));
        chk("model_busy", 32'(Busy), 32'(m_kind != 0));
        chk("model_done", 32'(Done), 32'(m_done));
        chk("model_err", 32'(Err), 32'(m_err));
    endtask

    task automatic idle_inputs();
        LD_MAR = 1'b0; LD_MDR = 1'b0; MIO_EN = 1'b0;
        Rd_req = 1'b0; Wr_req = 1'b0;
    endtask

    initial begin
        int n_oe, n_we, n_ce, done_at, bad_hold;
        checks = 0; failures = 0;
        Reset_n = 1'b0; idle_inputs(); Bus_in = 16'h0; Mem_rdata = 16'h0;
        #12;
        @(negedge Clk);
        Reset_n = 1'b1;
        cyc();
        chk("reset_mar", 32'(MAR), 32'h0);
        chk("reset_mdr", 32'(MDR), 32'h0);
        chk("reset_strobes", 32'({Mem_CE_n, Mem_OE_n, Mem_WE_n}), 32'b111);
        chk("reset_busy_done", 32'({Busy, Done}), 32'b00);

        // Directed read at 3000 returning 1234
        LD_MAR = 1'b1; Bus_in = 16'h3000;
        cyc();
        LD_MAR = 1'b0; Rd_req = 1'b1; Mem_rdata = 16'h1234;
        cyc();
        Rd_req = 1'b0;
        n_oe = 0; done_at = -1;
        for (int i = 0; i < 8; i++) begin
            if (!Mem_OE_n) n_oe++;
            if (Done && done_at < 0) done_at = i;
            cyc();
        end
        chk("read_oe_cycles", 32'(n_oe), 32'd3);
        chk("read_done_at", 32'(done_at), 32'd3);
        LD_MDR = 1'b1; MIO_EN = 1'b1;
        cyc();
        idle_inputs();
        chk("read_mdr", 32'(MDR), 32'h1234);

        // Directed write of ABCD to 3001; bus loads attempted while busy
        LD_MAR = 1'b1; Bus_in = 16'h3001;
        cyc();
        LD_MAR = 1'b0; LD_MDR = 1'b1; Bus_in = 16'hABCD;
        cyc();
        LD_MDR = 1'b0; Wr_req = 1'b1;
        cyc();
        Wr_req = 1'b0;
        n_we = 0; n_ce = 0; done_at = -1; bad_hold = 0;
        for (int i = 0; i < 8; i++) begin
            if (!Mem_WE_n) n_we++;
            if (!Mem_CE_n) begin
                n_ce++;
                if (Mem_addr !== 16'h3001 || Mem_wdata !== 16'hABCD) bad_hold++;
            end
            if (Done && done_at < 0) done_at = i;
            LD_MAR = (i < 4); LD_MDR = (i < 4); Bus_in = (i < 4) ? 16'hFFFF : 16'h0;
            cyc();
        end
        idle_inputs();
        chk("write_we_cycles", 32'(n_we), 32'd3);
        chk("write_ce_cycles", 32'(n_ce), 32'd4);
        chk("write_done_at", 32'(done_at), 32'd4);
        chk("write_hold", 32'(bad_hold), 32'd0);
        chk("write_mar_kept", 32'(MAR), 32'h3001);

        // Simultaneous read and write: read wins
        Rd_req = 1'b1; Wr_req = 1'b1; Mem_rdata = 16'h5A5A;
        cyc();
        idle_inputs();
        n_we = 0; n_oe = 0;
        for (int i = 0; i < 6; i++) begin
            if (!Mem_WE_n) n_we++;
            if (!Mem_OE_n) n_oe++;
            cyc();
        end
        chk("collide_no_write", 32'(n_we), 32'd0);
        chk("collide_read", 32'(n_oe), 32'd3);
        chk("collide_err", 32'(Err), 32'(ERR_EN));

        // Busy guard: LD_MAR and Wr_req during a read are ignored
        Rd_req = 1'b1;
        cyc();
        Rd_req = 1'b0; LD_MAR = 1'b1; Bus_in = 16'hFFFF; Wr_req = 1'b1;
        cyc();
        idle_inputs();
        n_we = 0;
        for (int i = 0; i < 6; i++) begin
            if (!Mem_WE_n) n_we++;
            cyc();
        end
        chk("guard_no_write", 32'(n_we), 32'd0);
        chk("guard_mar", 32'(MAR), 32'h3001);

        // Reset in the second WRITE cycle aborts without Done
        Wr_req = 1'b1;
        cyc();
        Wr_req = 1'b0;
        cyc();
        chk("midwrite_we_low", 32'(Mem_WE_n), 32'd0);
        #2 Reset_n = 1'b0;
        #1;
        chk("abort_strobes", 32'({Mem_CE_n, Mem_OE_n, Mem_WE_n}), 32'b111);
        chk("abort_busy_done", 32'({Busy, Done}), 32'b00);
        cyc();
        Reset_n = 1'b1;
        done_at = 0;
        for (int i = 0; i < 6; i++) begin
            if (Done) done_at++;
            cyc();
        end
        chk("abort_no_done", 32'(done_at), 32'd0);
        chk("abort_mar", 32'(MAR), 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            LD_MAR    = ($urandom_range(0, 9) < 3);
            LD_MDR    = ($urandom_range(0, 9) < 3);
            MIO_EN    = 1'($urandom_range(0, 1));
            Bus_in    = 16'($urandom);
            Rd_req    = ($urandom_range(0, 9) < 2);
            Wr_req    = ($urandom_range(0, 9) < 2);
            Mem_rdata = 16'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                #2 Reset_n = 1'b0;
                cyc();
                Reset_n = 1'b1;
            end else begin
                cyc();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
